// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames SYNC/CMD/LEN/payload/XOR-checksum packets from the UART byte strobe; define PARSER_STATS_EN for saturating packet/error counters
module uart_cmd_parser #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000,
  localparam int        AW             = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1
) (
  input  logic          iCE_CLK,
  input  logic          RST_N,
  input  logic [7:0]    RX_BYTE,
  input  logic          RX_VALID,
  output logic          CMD_VALID,
  output logic [7:0]    CMD_OP,
  output logic [7:0]    CMD_LEN,
  input  logic          CMD_ACK,
  input  logic [AW-1:0] PAYLOAD_ADDR,
  output logic [7:0]    PAYLOAD_DATA,
  output logic          ERR,
  output logic [1:0]    ERR_CODE
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]   STAT_PKTS,
  output logic [7:0]    STAT_CSUM_ERR,
  output logic [7:0]    STAT_OTHER_ERR
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CSUM, HOLD} state_t;
  state_t        state;
  logic [7:0]    acc, op_sh, len_sh, idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    pay_buf [1 << AW];
  logic          in_pkt, tmo;
  assign in_pkt = state inside {GET_CMD, GET_LEN, GET_PAY, GET_CSUM};
  assign tmo = in_pkt && !RX_VALID && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign PAYLOAD_DATA = pay_buf[PAYLOAD_ADDR];
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      CMD_VALID <= 1'b0;
      CMD_OP <= '0;
      CMD_LEN <= '0;
      ERR <= 1'b0;
      ERR_CODE <= '0;
      acc <= '0;
      op_sh <= '0;
      len_sh <= '0;
      idx <= '0;
      tcnt <= '0;
    end else begin
      ERR <= 1'b0;
      tcnt <= in_pkt && !RX_VALID && !tmo ? tcnt + 1'b1 : '0;
      if (tmo) begin
        state <= IDLE;
        ERR <= 1'b1;
        ERR_CODE <= 2'd3;
      end else begin
        case (state)
          IDLE: if (RX_VALID && RX_BYTE == SYNC_BYTE) begin
            state <= GET_CMD;
            acc <= '0;
          end
          GET_CMD: if (RX_VALID) begin
            op_sh <= RX_BYTE;
            acc <= RX_BYTE;
            state <= GET_LEN;
          end
          GET_LEN: if (RX_VALID) begin
            acc <= acc ^ RX_BYTE;
            if (RX_BYTE > 8'(MAX_LEN)) begin
              state <= IDLE;
              ERR <= 1'b1;
              ERR_CODE <= 2'd2;
            end else begin
              len_sh <= RX_BYTE;
              idx <= '0;
              state <= RX_BYTE == 8'd0 ? GET_CSUM : GET_PAY;
            end
          end
          GET_PAY: if (RX_VALID) begin
            acc <= acc ^ RX_BYTE;
            idx <= idx + 8'd1;
            if (idx + 8'd1 == len_sh) state <= GET_CSUM;
          end
          GET_CSUM: if (RX_VALID) begin
            if (RX_BYTE == acc) begin
              state <= HOLD;
              CMD_VALID <= 1'b1;
              CMD_OP <= op_sh;
              CMD_LEN <= len_sh;
            end else begin
              state <= IDLE;
              ERR <= 1'b1;
              ERR_CODE <= 2'd1;
            end
          end
          HOLD: if (CMD_ACK) begin
            // a byte arriving with the ACK is treated as if already in IDLE
            CMD_VALID <= 1'b0;
            acc <= '0;
            state <= RX_VALID && RX_BYTE == SYNC_BYTE ? GET_CMD : IDLE;
          end else if (RX_VALID) begin
            ERR <= 1'b1;
            ERR_CODE <= 2'd0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge iCE_CLK)
    if (state == GET_PAY && RX_VALID) pay_buf[idx[AW-1:0]] <= RX_BYTE;
`ifdef PARSER_STATS_EN
  always_ff @(posedge iCE_CLK or negedge RST_N) begin
    if (!RST_N) begin
      STAT_PKTS <= '0;
      STAT_CSUM_ERR <= '0;
      STAT_OTHER_ERR <= '0;
    end else begin
      if (state == GET_CSUM && RX_VALID && RX_BYTE == acc && STAT_PKTS != '1) STAT_PKTS <= STAT_PKTS + 1'b1;
      if (ERR && ERR_CODE == 2'd1 && STAT_CSUM_ERR != '1) STAT_CSUM_ERR <= STAT_CSUM_ERR + 1'b1;
      if (ERR && ERR_CODE != 2'd1 && STAT_OTHER_ERR != '1) STAT_OTHER_ERR <= STAT_OTHER_ERR + 1'b1;
    end
  end
`endif
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver stage. Consumes its registered received-byte strobe and byte, and frames the byte stream into debugger command packets: SYNC, CMD, LEN, payload, XOR checksum. A validated packet is presented as a held command with a random-access payload buffer until the command executor acknowledges it. Malformed, stalled or overrun traffic raises a one-cycle error pulse with a sticky error code.

Parameters:
- MAX_LEN, 16: maximum payload bytes; legal range 1..255; buffer depth.
- SYNC_BYTE, 8'hA5: packet start marker.
- TIMEOUT_CYCLES, 50000: maximum idle clocks between bytes inside a packet; 4 byte times at 9600 baud on a 12 MHz clock.

Ports:
- iCE_CLK, input, 1: system clock, 12 MHz.
- RST_N, input, 1: asynchronous active-low reset.
- RX_BYTE, input, 8: received byte; sampled only when RX_VALID=1.
- RX_VALID, input, 1: one-cycle strobe per received byte, driven by the receiver's RECEIVED.
- CMD_VALID, output, 1: a validated packet is held.
- CMD_OP, output, 8: command opcode.
- CMD_LEN, output, 8: payload length.
- CMD_ACK, input, 1: executor consumed the command. Ignored unless CMD_VALID=1.
- PAYLOAD_ADDR, input, clog2(MAX_LEN) or 1 if MAX_LEN=1: payload read index.
- PAYLOAD_DATA, output, 8: combinational read of buffer[PAYLOAD_ADDR].
- ERR, output, 1: one-cycle error pulse.
- ERR_CODE, output, 2: last error. 0 = overrun, 1 = checksum, 2 = length, 3 = timeout.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - CMD_VALID, ERR, ERR_CODE, CMD_OP, CMD_LEN, checksum accumulator, byte index and timeout counter all = 0.
  - Buffer contents are not reset.
  - Reset mid-packet or mid-HOLD discards everything.
- FSM states: IDLE, GET_CMD, GET_LEN, GET_PAY, GET_CSUM, HOLD. All transitions occur on an RX_VALID cycle except the timeout and ACK transitions.
- IDLE:
  - RX_VALID with RX_BYTE=SYNC_BYTE -> GET_CMD; accumulator cleared.
  - Any other byte is silently dropped.
- GET_CMD: latch the opcode into a shadow register; acc = byte; -> GET_LEN.
- GET_LEN:
  - acc ^= byte.
  - byte > MAX_LEN -> IDLE with ERR, code 2.
  - byte = 0 -> GET_CSUM.
  - Otherwise latch the length, index = 0, -> GET_PAY.
- GET_PAY:
  - buffer[index] = byte; acc ^= byte; index++.
  - Stays in GET_PAY until index reaches LEN, then -> GET_CSUM.
- GET_CSUM:
  - byte = acc -> HOLD; CMD_VALID=1 on the clock edge after the checksum strobe, so latency is 1 cycle. CMD_OP and CMD_LEN update at the same edge.
  - byte != acc -> IDLE with ERR, code 1; CMD_OP and CMD_LEN are unchanged.
- Timeout:
  - In GET_CMD through GET_CSUM, the counter clears on every RX_VALID and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 without a byte -> IDLE with ERR, code 3.
  - The counter is held at 0 in IDLE and HOLD.
- HOLD:
  - CMD_VALID, CMD_OP, CMD_LEN and the buffer are stable.
  - CMD_ACK -> IDLE; CMD_VALID falls on the next edge.
  - RX_VALID without CMD_ACK in the same cycle: byte dropped, ERR, code 0, state stays HOLD.
  - RX_VALID with CMD_ACK in the same cycle: the byte is processed exactly as in IDLE, so a SYNC byte goes straight to GET_CMD. No error.
- ERR is high for exactly one cycle per event. ERR_CODE updates on the same edge and holds until the next error.
- The payload buffer is written only in GET_PAY, never while CMD_VALID=1. Reads at PAYLOAD_ADDR >= CMD_LEN return stale data; this is not an error.
- All arithmetic is 8-bit XOR. The index wraps never, because it is bounded by LEN <= MAX_LEN.

Optional Feature:
- PARSER_STATS_EN defined adds three outputs:
  - STAT_PKTS (16 bits): count of good packets.
  - STAT_CSUM_ERR (8 bits): count of checksum errors.
  - STAT_OTHER_ERR (8 bits): count of length, timeout and overrun errors.
- All three counters saturate, never wrap, and reset to 0 on RST_N.
- Undefined: these ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Bytes A5 10 02 11 22 21 at 1 byte/1042 clocks -> CMD_VALID=1 one cycle after the 0x21 strobe; CMD_OP=0x10, CMD_LEN=2, PAYLOAD[0]=0x11, PAYLOAD[1]=0x22; held until CMD_ACK, drops the following cycle.
- Same packet with checksum 0x20 -> ERR pulse, ERR_CODE=1, CMD_VALID stays 0, state IDLE; then A5 20 00 20 -> CMD_VALID, CMD_OP=0x20, CMD_LEN=0.
- A5 30 11 with MAX_LEN=16 -> ERR, ERR_CODE=2 on the LEN strobe; the next byte 0x11 is ignored in IDLE.
- A5 40, then silence for 50000 clocks -> ERR, ERR_CODE=3; a subsequent full valid packet is accepted normally.
- Good packet held, not acked, extra byte 0x55 arrives -> ERR, ERR_CODE=0, CMD_VALID and payload unchanged. Then CMD_ACK in the same cycle as byte A5 -> no ERR, the parser enters GET_CMD and the next packet completes.
- RST_N pulsed low asynchronously mid-payload -> all outputs 0 immediately; post-reset packet parses correctly. With PARSER_STATS_EN: 3 good + 1 bad-checksum + 1 timeout -> STAT_PKTS=3, STAT_CSUM_ERR=1, STAT_OTHER_ERR=1.
